// File: rtl/c2_pipe_cell_if.sv
// Bundles the C-cell config, select-term, data and result signals.
// master drives the operation; slave is the cell itself.
interface c2_pipe_cell_if #(
  parameter int SIZE = 5
);
  logic            cfg_we;
  logic [2:0]      cfg_mode;
  logic [2:0]      mode;
  logic            in_valid;
  logic            stall;
  logic [SIZE-1:0] D00;
  logic [SIZE-1:0] D01;
  logic [SIZE-1:0] D10;
  logic [SIZE-1:0] D11;
  logic            A1;
  logic            B1;
  logic            A0;
  logic            B0;
  logic [SIZE-1:0] out;
  logic            out_valid;
  logic [1:0]      sel_dbg;

  modport master (
    output cfg_we, cfg_mode, in_valid, stall,
    output D00, D01, D10, D11, A1, B1, A0, B0,
    input  mode, out, out_valid, sel_dbg
  );

  modport slave (
    input  cfg_we, cfg_mode, in_valid, stall,
    input  D00, D01, D10, D11, A1, B1, A0, B0,
    output mode, out, out_valid, sel_dbg
  );
endinterface

// File: rtl/c2_pipe_cell.sv
// Configurable 4:1 C-cell: mode-driven select, two registered stages, 2-cycle latency.
// stall freezes both stages (mode writes still land); sync reset flushes everything.
module c2_pipe_cell #(
  parameter int SIZE = 5
) (
  input  logic          clk,
  input  logic          rst,
  c2_pipe_cell_if.slave bus
);
  logic [2:0]            mode_q;
  logic                  s1_valid;
  logic [1:0]            sel_q;
  logic [3:0][SIZE-1:0]  d_q;
  logic [SIZE-1:0]       out_q;
  logic                  out_valid_q;

  logic                  s0;
  logic                  s1;
  logic [1:0]            sel;

  // Select uses the mode held before the edge, so a same-edge cfg write has no effect on it.
  always_comb begin
    s0  = mode_q[0] ? (bus.A0 | bus.B0) : (bus.A0 & bus.B0);
    s1  = mode_q[1] ? (bus.A1 & bus.B1) : (bus.A1 | bus.B1);
    sel = {s1, s0} ^ {2{mode_q[2]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 3'b000;
      s1_valid    <= 1'b0;
      sel_q       <= 2'b00;
      d_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        mode_q <= bus.cfg_mode;
      end
      if (!bus.stall) begin
        s1_valid    <= bus.in_valid;
        sel_q       <= sel;
        d_q         <= {bus.D11, bus.D10, bus.D01, bus.D00};
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_q <= d_q[sel_q];
        end
      end
    end
  end

  assign bus.mode      = mode_q;
  assign bus.sel_dbg   = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_c2_pipe_cell.sv
// Directed bench for c2_pipe_cell with a result scoreboard and independent mode/select model.
module tb_c2_pipe_cell;
  logic clk;
  logic rst;

  c2_pipe_cell_if #(.SIZE(5)) bus();

  c2_pipe_cell #(.SIZE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [4:0] exp_q[$];
  logic [4:0] dw[4];
  logic [4:0] last_out;
  logic [2:0] mode_m;
  logic [3:0] cur_abab;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // (A1,B1,A0,B0) packed as abab[3:0]
  function automatic logic [1:0] sel_of(input logic [2:0] m, input logic [3:0] abab);
    logic s0, s1;
    s0 = m[0] ? (abab[1] | abab[0]) : (abab[1] & abab[0]);
    s1 = m[1] ? (abab[3] & abab[2]) : (abab[3] | abab[2]);
    return {s1, s0} ^ {2{m[2]}};
  endfunction

  task automatic drive(input logic v, input logic [3:0] abab);
    bus.in_valid = v;
    cur_abab     = abab;
    {bus.A1, bus.B1, bus.A0, bus.B0} = abab;
  endtask

  // One clock edge: push sampled ops, pop completed results, check all outputs.
  task automatic tick(input logic exp_ov);
    logic       ps, pr, pv, pwe;
    logic [2:0] pm;
    logic [1:0] s;
    ps  = bus.stall;
    pr  = rst;
    pv  = bus.in_valid;
    pwe = bus.cfg_we;
    pm  = bus.cfg_mode;
    s   = sel_of(mode_m, cur_abab);
    @(posedge clk);
    #1;
    if (pr) begin
      exp_q.delete();
      last_out = '0;
      mode_m   = '0;
      chk("rst_sel_dbg", 8'(bus.sel_dbg), 8'd0);
    end else begin
      if (!ps && bus.out_valid === 1'b1) begin
        chk("sb_nonempty", 8'(exp_q.size() != 0), 8'd1);
        if (exp_q.size() != 0) last_out = exp_q.pop_front();
      end
      if (pv && !ps) begin
        exp_q.push_back(dw[s]);
        chk("sel_dbg", 8'(bus.sel_dbg), 8'(s));
      end
      if (pwe) mode_m = pm;
    end
    chk("out_valid", 8'(bus.out_valid), 8'(exp_ov));
    chk("out", 8'(bus.out), 8'(last_out));
    chk("mode", 8'(bus.mode), 8'(mode_m));
  endtask

  initial begin
    dw[0] = 5'h01; dw[1] = 5'h02; dw[2] = 5'h04; dw[3] = 5'h08;
    last_out = '0;
    mode_m   = '0;

    // Reset with random inputs, stall and cfg_we asserted
    rst          = 1'b1;
    bus.stall    = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_mode = 3'($urandom_range(7, 1));
    bus.D00 = 5'($urandom); bus.D01 = 5'($urandom);
    bus.D10 = 5'($urandom); bus.D11 = 5'($urandom);
    drive(1'b1, 4'($urandom));
    tick(1'b0);
    drive(1'b1, 4'($urandom));
    tick(1'b0);

    rst        = 1'b0;
    bus.stall  = 1'b0;
    bus.cfg_we = 1'b0;
    bus.D00 = dw[0]; bus.D01 = dw[1]; bus.D10 = dw[2]; bus.D11 = dw[3];
    drive(1'b0, 4'b0000);
    tick(1'b0);

    // Default mode, back to back
    drive(1'b1, 4'b0000); tick(1'b0);
    drive(1'b1, 4'b0011); tick(1'b1);
    drive(1'b1, 4'b1000); tick(1'b1);
    drive(1'b1, 4'b1011); tick(1'b1);
    drive(1'b0, 4'b0000); tick(1'b1);
    tick(1'b0);
    tick(1'b0);

    // Mode write: same-edge op uses old mode, later ops the new one
    bus.cfg_we = 1'b1; bus.cfg_mode = 3'b011;
    drive(1'b1, 4'b1010); tick(1'b0);
    bus.cfg_we = 1'b0;
    drive(1'b1, 4'b1010); tick(1'b1);
    bus.cfg_we = 1'b1; bus.cfg_mode = 3'b111;
    drive(1'b0, 4'b0000); tick(1'b1);
    bus.cfg_we = 1'b0;
    drive(1'b1, 4'b1010); tick(1'b0);
    bus.cfg_we = 1'b1; bus.cfg_mode = 3'b000;
    drive(1'b0, 4'b0000); tick(1'b1);
    bus.cfg_we = 1'b0;
    tick(1'b0);

    // Stall for 3 cycles right after the first result
    drive(1'b1, 4'b0011); tick(1'b0);
    drive(1'b1, 4'b1000); tick(1'b1);
    drive(1'b1, 4'b1011);
    bus.stall = 1'b1;
    tick(1'b1); tick(1'b1); tick(1'b1);
    bus.stall = 1'b0;
    tick(1'b1);
    drive(1'b0, 4'b0000); tick(1'b1);
    tick(1'b0);

    // Valid gaps: out holds while out_valid is low
    drive(1'b1, 4'b0011); tick(1'b0);
    drive(1'b0, 4'($urandom)); tick(1'b1);
    drive(1'b0, 4'($urandom)); tick(1'b0);
    drive(1'b1, 4'b1000); tick(1'b0);
    drive(1'b0, 4'b0000); tick(1'b1);
    tick(1'b0);

    // Reset mid-flight beats stall and cfg_we; in-flight ops vanish
    drive(1'b1, 4'b0011); tick(1'b0);
    rst = 1'b1; bus.stall = 1'b1; bus.cfg_we = 1'b1; bus.cfg_mode = 3'b101;
    drive(1'b1, 4'b1000); tick(1'b0);
    rst = 1'b0; bus.stall = 1'b0; bus.cfg_we = 1'b0;
    drive(1'b0, 4'b0000); tick(1'b0);
    tick(1'b0);
    drive(1'b1, 4'b1011); tick(1'b0);
    drive(1'b0, 4'b0000); tick(1'b1);
    tick(1'b0);

    chk("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
